// File: rtl/pipelined_armv8.sv
// pipelined_armv8: five-stage (IF/ID/EX/MEM/WB) in-order LEGv8/ARMv8 integer core,
// top of the FPGA build.
//   clock    : rising-edge system clock
//   reset    : asynchronous, active-low; clears PC and pipeline registers
//   switches : [4:0] selects the register shown on the LEDs, [17:5] unused
//   leds     : [15:0] low half of the selected register, [26:16] PC_out[12:2]
// Instruction memory, data memory and register file are preloaded externally and
// are not touched by reset.

package pipelined_armv8_pkg;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_op_t;
endpackage

// instruction_memory: 64x32 word store, combinational read. The load port is
// only used by a boot loader; the core ties it off.
module instruction_memory (
  input  logic        clock,
  input  logic        load_en,
  input  logic [5:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic [5:0]  addr,
  output logic [31:0] data
);
  logic [31:0] memory [64];

  always_ff @(posedge clock) begin
    if (load_en) memory[load_addr] <= load_data;
  end

  assign data = memory[addr];
endmodule

// instruction_fetch: word-indexes the instruction memory with pc[7:2], so the
// PC wraps through the 64-word store.
module instruction_fetch (
  input  logic        clock,
  input  logic [63:0] pc,
  output logic [31:0] instruction
);
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[63:8], pc[1:0]};

  instruction_memory instruction_memory (
    .clock     (clock),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data ('0),
    .addr      (pc[7:2]),
    .data      (instruction)
  );
endmodule

// registers: 32x64 register file, two read ports plus a display port, one write
// port. X31 reads as zero and is never written. A write in the same cycle is
// bypassed to the read ports (write-before-read).
module registers (
  input  logic        clock,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  input  logic [4:0]  display_reg,
  input  logic        write_en,
  input  logic [4:0]  write_reg,
  input  logic [63:0] write_data,
  output logic [63:0] read_data1,
  output logic [63:0] read_data2,
  output logic [15:0] display_data
);
  logic [63:0] regfile [32];

  always_ff @(posedge clock) begin
    if (write_en && write_reg != 5'd31) regfile[write_reg] <= write_data;
  end

  assign read_data1 = (read_reg1 == 5'd31) ? '0 :
                      (write_en && write_reg == read_reg1) ? write_data : regfile[read_reg1];
  assign read_data2 = (read_reg2 == 5'd31) ? '0 :
                      (write_en && write_reg == read_reg2) ? write_data : regfile[read_reg2];
  assign display_data = (display_reg == 5'd31) ? '0 : regfile[display_reg][15:0];
endmodule

// instruction_decode: decodes the IF/ID instruction, reads the register file and
// resolves branches using the branch's own address (pc).
module instruction_decode import pipelined_armv8_pkg::*; (
  input  logic        clock,
  input  logic [31:0] instruction,
  input  logic [63:0] pc,
  input  logic        Regwrite_reg,
  input  logic [4:0]  write_reg,
  input  logic [63:0] write_data,
  input  logic [4:0]  display_reg,
  output logic [15:0] display_data,
  output logic [63:0] read_data1,
  output logic [63:0] read_data2,
  output logic [63:0] imm,
  output logic [4:0]  rn,
  output logic [4:0]  reg2,
  output logic [4:0]  rd,
  output logic        uses_rn,
  output logic        uses_reg2,
  output logic        RegWrite,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        Branchlink,
  output alu_op_t     alu_op,
  output logic        branch_taken,
  output logic [63:0] branch_target
);
  logic is_add, is_sub, is_and, is_orr, is_addi, is_ldur, is_stur, is_b, is_cbz, is_rtype;

  assign is_add   = instruction[31:21] == 11'b10001011000;
  assign is_sub   = instruction[31:21] == 11'b11001011000;
  assign is_and   = instruction[31:21] == 11'b10001010000;
  assign is_orr   = instruction[31:21] == 11'b10101010000;
  assign is_addi  = instruction[31:22] == 10'b1001000100;
  assign is_ldur  = instruction[31:21] == 11'b11111000010;
  assign is_stur  = instruction[31:21] == 11'b11111000000;
  assign is_b     = instruction[31:26] == 6'b000101;
  assign Branchlink = instruction[31:26] == 6'b100101;
  assign is_cbz   = instruction[31:24] == 8'b10110100;
  assign is_rtype = is_add | is_sub | is_and | is_orr;

  assign rn   = instruction[9:5];
  // STUR and CBZ read Rt through the second port instead of Rm.
  assign reg2 = (is_stur | is_cbz) ? instruction[4:0] : instruction[20:16];
  assign rd   = Branchlink ? 5'd30 : instruction[4:0];

  assign uses_rn    = is_rtype | is_addi | is_ldur | is_stur;
  assign uses_reg2  = is_rtype | is_stur | is_cbz;
  assign RegWrite   = is_rtype | is_addi | is_ldur | Branchlink;
  assign mem_read   = is_ldur;
  assign mem_write  = is_stur;
  assign mem_to_reg = is_ldur;
  assign alu_src    = is_addi | is_ldur | is_stur;

  assign imm = is_addi ? {52'd0, instruction[21:10]}
                       : {{55{instruction[20]}}, instruction[20:12]};

  always_comb begin
    alu_op = ALU_ADD;
    if (is_sub)      alu_op = ALU_SUB;
    else if (is_and) alu_op = ALU_AND;
    else if (is_orr) alu_op = ALU_ORR;
  end

  registers registers (
    .clock        (clock),
    .read_reg1    (rn),
    .read_reg2    (reg2),
    .display_reg  (display_reg),
    .write_en     (Regwrite_reg),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .display_data (display_data)
  );

  assign branch_taken  = is_b | Branchlink | (is_cbz && read_data2 == 64'd0);
  assign branch_target = is_cbz ? pc + {{43{instruction[23]}}, instruction[23:5], 2'b00}
                                : pc + {{36{instruction[25]}}, instruction[25:0], 2'b00};
endmodule

module pipelined_armv8 import pipelined_armv8_pkg::*; (
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] switches,
  output logic [26:0] leds
);
  // IF / IF-ID
  logic [63:0] PC_out;
  logic [31:0] fetched;
  logic [31:0] instruction_IF_ID;
  logic [63:0] pc_if_id;

  // ID
  logic [63:0] read_data1, read_data2, imm, branch_target;
  logic [4:0]  rn, reg2, rd;
  logic        uses_rn, uses_reg2, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
  logic        branch_link, branch_taken, stall;
  alu_op_t     alu_op;
  logic [15:0] display_data;

  // ID/EX
  logic        idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg, idex_alu_src, idex_link;
  alu_op_t     idex_alu_op;
  logic [4:0]  idex_rn, idex_reg2, idex_rd;
  logic [63:0] idex_a, idex_b, idex_imm, idex_pc;

  // EX
  logic [63:0] fwd_a, fwd_b, alu_b, alu_out, ex_result;

  // EX/MEM
  logic        exmem_reg_write, exmem_mem_write, exmem_mem_to_reg;
  logic [4:0]  exmem_rd;
  logic [63:0] exmem_result, exmem_store_data;

  // MEM, MEM/WB, WB
  logic [63:0] data_memory [64];
  logic [63:0] mem_read_data;
  logic        memwb_reg_write, memwb_mem_to_reg;
  logic [4:0]  memwb_rd;
  logic [63:0] memwb_result, memwb_load_data, wb_data;

  logic unused_switches;
  assign unused_switches = ^switches[17:5];

  instruction_fetch instruction_fetch (
    .clock       (clock),
    .pc          (PC_out),
    .instruction (fetched)
  );

  // A load in EX whose Rt feeds an ID source holds PC and IF/ID for one cycle;
  // a branch seen during the stall resolves the cycle after.
  assign stall = idex_mem_read && idex_rd != 5'd31 &&
                 ((uses_rn && rn == idex_rd) || (uses_reg2 && reg2 == idex_rd));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      PC_out            <= '0;
      instruction_IF_ID <= '0;
      pc_if_id          <= '0;
    end else if (!stall) begin
      PC_out            <= branch_taken ? branch_target : PC_out + 64'd4;
      instruction_IF_ID <= branch_taken ? '0 : fetched;
      pc_if_id          <= PC_out;
    end
  end

  instruction_decode instruction_decode (
    .clock         (clock),
    .instruction   (instruction_IF_ID),
    .pc            (pc_if_id),
    .Regwrite_reg  (memwb_reg_write),
    .write_reg     (memwb_rd),
    .write_data    (wb_data),
    .display_reg   (switches[4:0]),
    .display_data  (display_data),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .imm           (imm),
    .rn            (rn),
    .reg2          (reg2),
    .rd            (rd),
    .uses_rn       (uses_rn),
    .uses_reg2     (uses_reg2),
    .RegWrite      (reg_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .alu_src       (alu_src),
    .Branchlink    (branch_link),
    .alu_op        (alu_op),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_mem_to_reg <= 1'b0;
      idex_alu_src    <= 1'b0;
      idex_link       <= 1'b0;
      idex_alu_op     <= ALU_ADD;
      idex_rn         <= '0;
      idex_reg2       <= '0;
      idex_rd         <= '0;
      idex_a          <= '0;
      idex_b          <= '0;
      idex_imm        <= '0;
      idex_pc         <= '0;
    end else if (stall) begin
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_mem_to_reg <= 1'b0;
      idex_link       <= 1'b0;
    end else begin
      idex_reg_write  <= reg_write;
      idex_mem_read   <= mem_read;
      idex_mem_write  <= mem_write;
      idex_mem_to_reg <= mem_to_reg;
      idex_alu_src    <= alu_src;
      idex_link       <= branch_link;
      idex_alu_op     <= alu_op;
      idex_rn         <= rn;
      idex_reg2       <= reg2;
      idex_rd         <= rd;
      idex_a          <= read_data1;
      idex_b          <= read_data2;
      idex_imm        <= imm;
      idex_pc         <= pc_if_id;
    end
  end

  // EX/MEM has priority over MEM/WB when both hold the operand's producer.
  always_comb begin
    fwd_a = idex_a;
    if (exmem_reg_write && exmem_rd != 5'd31 && exmem_rd == idex_rn)
      fwd_a = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd31 && memwb_rd == idex_rn)
      fwd_a = wb_data;
    fwd_b = idex_b;
    if (exmem_reg_write && exmem_rd != 5'd31 && exmem_rd == idex_reg2)
      fwd_b = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd31 && memwb_rd == idex_reg2)
      fwd_b = wb_data;
  end

  assign alu_b = idex_alu_src ? idex_imm : fwd_b;

  always_comb begin
    case (idex_alu_op)
      ALU_SUB: alu_out = fwd_a - alu_b;
      ALU_AND: alu_out = fwd_a & alu_b;
      ALU_ORR: alu_out = fwd_a | alu_b;
      default: alu_out = fwd_a + alu_b;
    endcase
  end

  // BL carries its link address as the "ALU result" so forwarding needs no special case.
  assign ex_result = idex_link ? idex_pc + 64'd4 : alu_out;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exmem_reg_write  <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
      exmem_rd         <= '0;
      exmem_result     <= '0;
      exmem_store_data <= '0;
    end else begin
      exmem_reg_write  <= idex_reg_write;
      exmem_mem_write  <= idex_mem_write;
      exmem_mem_to_reg <= idex_mem_to_reg;
      exmem_rd         <= idex_rd;
      exmem_result     <= ex_result;
      exmem_store_data <= fwd_b;
    end
  end

  always_ff @(posedge clock) begin
    if (exmem_mem_write) data_memory[exmem_result[8:3]] <= exmem_store_data;
  end

  assign mem_read_data = data_memory[exmem_result[8:3]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      memwb_reg_write  <= 1'b0;
      memwb_mem_to_reg <= 1'b0;
      memwb_rd         <= '0;
      memwb_result     <= '0;
      memwb_load_data  <= '0;
    end else begin
      memwb_reg_write  <= exmem_reg_write;
      memwb_mem_to_reg <= exmem_mem_to_reg;
      memwb_rd         <= exmem_rd;
      memwb_result     <= exmem_result;
      memwb_load_data  <= mem_read_data;
    end
  end

  assign wb_data = memwb_mem_to_reg ? memwb_load_data : memwb_result;

  assign leds = {PC_out[12:2], display_data};
endmodule

// File: tb/tb_pipelined_armv8.sv
// Directed bench for pipelined_armv8: preloads a short program and register
// values, then checks the PC sequence, squashes, stall, link, forwarding results,
// LED display and asynchronous reset against hand-computed values.
module tb_pipelined_armv8;
  logic        clock;
  logic        reset;
  logic [17:0] switches;
  logic [26:0] leds;

  int unsigned n_checks;
  int unsigned n_passed;

  logic [31:0] prog [64];
  logic [63:0] exp_pc [1:22];
  logic [26:0] exp_leds;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;

  pipelined_armv8 dut (
    .clock    (clock),
    .reset    (reset),
    .switches (switches),
    .leds     (leds)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rd,
                                        input logic [4:0] rn, input logic [4:0] rm);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rn,
                                           input logic [11:0] imm);
    return {10'b1001000100, imm, rn, rd};
  endfunction

  function automatic logic [31:0] enc_mem(input logic [10:0] op, input logic [4:0] rt,
                                          input logic [4:0] rn, input logic [8:0] imm9);
    return {op, imm9, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] enc_b(input logic [5:0] op, input logic [25:0] imm);
    return {op, imm};
  endfunction

  function automatic logic [31:0] enc_cbz(input logic [4:0] rt, input logic [18:0] imm);
    return {8'b10110100, imm, rt};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_passed = 0;
    switches = '0;
    reset    = 1'b1;

    for (int i = 0; i < 64; i++) prog[i] = '0;
    prog[0]  = enc_b(OP_B, 26'd6);                    // 0x00 -> 0x18
    for (int i = 1; i <= 5; i++) prog[i] = enc_addi(5'd7, 5'd31, 12'd99);
    prog[6]  = enc_r(OP_ADD, 5'd2, 5'd16, 5'd18);     // X2 = 26
    prog[7]  = enc_b(OP_BL, 26'd2);                   // 0x1C -> 0x24, X30 = 0x20
    prog[8]  = enc_addi(5'd8, 5'd31, 12'd77);         // squashed
    prog[9]  = enc_r(OP_ADD, 5'd1, 5'd16, 5'd18);     // X1 = 26
    prog[10] = enc_r(OP_SUB, 5'd3, 5'd1, 5'd18);      // X3 = 20
    prog[11] = enc_mem(OP_STUR, 5'd16, 5'd31, 9'd8);  // M[1] = 20
    prog[12] = enc_mem(OP_LDUR, 5'd4, 5'd31, 9'd8);   // X4 = 20
    prog[13] = enc_r(OP_ADD, 5'd5, 5'd4, 5'd4);       // stall, X5 = 40
    prog[14] = enc_cbz(5'd31, 19'd3);                 // 0x38 -> 0x44
    prog[15] = enc_addi(5'd9, 5'd31, 12'd55);
    prog[16] = enc_addi(5'd9, 5'd31, 12'd55);
    prog[17] = enc_cbz(5'd16, 19'd2);                 // not taken
    prog[18] = enc_addi(5'd10, 5'd31, 12'd5);         // X10 = 5
    prog[19] = enc_r(OP_AND, 5'd11, 5'd16, 5'd18);    // X11 = 4
    prog[20] = enc_r(OP_ORR, 5'd12, 5'd16, 5'd18);    // X12 = 22
    prog[21] = enc_r(OP_ADD, 5'd15, 5'd11, 5'd12);    // X15 = 26
    prog[22] = enc_addi(5'd13, 5'd16, 12'hFFF);       // X13 = 4115
    prog[23] = enc_mem(OP_STUR, 5'd18, 5'd16, 9'h1FC);// M[2] = 6
    prog[24] = enc_mem(OP_LDUR, 5'd14, 5'd31, 9'd16); // X14 = 6
    prog[25] = enc_r(OP_SUB, 5'd17, 5'd31, 5'd18);    // X17 = -6
    prog[26] = enc_b(OP_B, 26'd0);                    // self loop at 0x68

    exp_pc[1]  = 64'h04; exp_pc[2]  = 64'h18; exp_pc[3]  = 64'h1C; exp_pc[4]  = 64'h20;
    exp_pc[5]  = 64'h24; exp_pc[6]  = 64'h28; exp_pc[7]  = 64'h2C; exp_pc[8]  = 64'h30;
    exp_pc[9]  = 64'h34; exp_pc[10] = 64'h38; exp_pc[11] = 64'h38; exp_pc[12] = 64'h3C;
    exp_pc[13] = 64'h44; exp_pc[14] = 64'h48; exp_pc[15] = 64'h4C; exp_pc[16] = 64'h50;
    exp_pc[17] = 64'h54; exp_pc[18] = 64'h58; exp_pc[19] = 64'h5C; exp_pc[20] = 64'h60;
    exp_pc[21] = 64'h64; exp_pc[22] = 64'h68;

    #2 reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      dut.instruction_fetch.instruction_memory.memory[i] = prog[i];
      dut.data_memory[i] = '0;
    end
    for (int i = 0; i < 32; i++) dut.instruction_decode.registers.regfile[i] = '0;
    dut.instruction_decode.registers.regfile[16] = 64'd20;
    dut.instruction_decode.registers.regfile[18] = 64'd6;

    #20;
    check("reset_pc", dut.PC_out, 64'd0);
    check("reset_ifid", {32'd0, dut.instruction_IF_ID}, 64'd0);

    @(negedge clock);
    reset = 1'b1;

    for (int k = 1; k <= 30; k++) begin
      step();
      check($sformatf("pc@%0d", k), dut.PC_out,
            (k <= 22) ? exp_pc[k] : ((k % 2 == 1) ? 64'h6C : 64'h68));
      if (k == 1) check("ifid_first_fetch", {32'd0, dut.instruction_IF_ID}, {32'd0, prog[0]});
      if (k == 2) check("b_squash", {32'd0, dut.instruction_IF_ID}, 64'd0);
      if (k == 3) check("branchlink_idle", {63'd0, dut.instruction_decode.Branchlink}, 64'd0);
      if (k == 4) begin
        check("branchlink_bl", {63'd0, dut.instruction_decode.Branchlink}, 64'd1);
        check("regwrite_bl", {63'd0, dut.instruction_decode.RegWrite}, 64'd1);
      end
      if (k == 5) begin
        check("bl_squash", {32'd0, dut.instruction_IF_ID}, 64'd0);
        check("wb_en_bubble", {63'd0, dut.instruction_decode.Regwrite_reg}, 64'd0);
      end
      if (k == 6) begin
        check("wb_en_add", {63'd0, dut.instruction_decode.Regwrite_reg}, 64'd1);
        check("x2_before_wb", dut.instruction_decode.registers.regfile[2], 64'd0);
      end
      if (k == 7) check("x2_after_wb", dut.instruction_decode.registers.regfile[2], 64'd26);
      if (k == 11) check("stall_hold_ifid", {32'd0, dut.instruction_IF_ID}, {32'd0, prog[13]});
      if (k == 13) check("cbz_taken_squash", {32'd0, dut.instruction_IF_ID}, 64'd0);
      if (k == 14) check("cbz_not_taken_ifid", {32'd0, dut.instruction_IF_ID}, {32'd0, prog[17]});
    end

    check("x1",  dut.instruction_decode.registers.regfile[1],  64'd26);
    check("x2",  dut.instruction_decode.registers.regfile[2],  64'd26);
    check("x3",  dut.instruction_decode.registers.regfile[3],  64'd20);
    check("x4",  dut.instruction_decode.registers.regfile[4],  64'd20);
    check("x5",  dut.instruction_decode.registers.regfile[5],  64'd40);
    check("x7",  dut.instruction_decode.registers.regfile[7],  64'd0);
    check("x8",  dut.instruction_decode.registers.regfile[8],  64'd0);
    check("x9",  dut.instruction_decode.registers.regfile[9],  64'd0);
    check("x10", dut.instruction_decode.registers.regfile[10], 64'd5);
    check("x11", dut.instruction_decode.registers.regfile[11], 64'd4);
    check("x12", dut.instruction_decode.registers.regfile[12], 64'd22);
    check("x13", dut.instruction_decode.registers.regfile[13], 64'd4115);
    check("x14", dut.instruction_decode.registers.regfile[14], 64'd6);
    check("x15", dut.instruction_decode.registers.regfile[15], 64'd26);
    check("x17", dut.instruction_decode.registers.regfile[17], 64'hFFFF_FFFF_FFFF_FFFA);
    check("x30", dut.instruction_decode.registers.regfile[30], 64'h20);
    check("mem1", dut.data_memory[1], 64'd20);
    check("mem2", dut.data_memory[2], 64'd6);

    switches = 18'd2;
    #1;
    exp_leds = {11'h01A, 16'd26};
    check("leds_x2_pc", {37'd0, leds}, {37'd0, exp_leds});

    #2 reset = 1'b0;
    #1;
    check("midreset_pc", dut.PC_out, 64'd0);
    check("midreset_ifid", {32'd0, dut.instruction_IF_ID}, 64'd0);
    check("midreset_x2", dut.instruction_decode.registers.regfile[2], 64'd26);
    exp_leds = {11'd0, 16'd26};
    check("midreset_leds", {37'd0, leds}, {37'd0, exp_leds});
    switches = 18'd17;
    #1;
    exp_leds = {11'd0, 16'hFFFA};
    check("leds_x17", {37'd0, leds}, {37'd0, exp_leds});
    switches = 18'd31;
    #1;
    check("leds_x31", {37'd0, leds}, 64'd0);

    @(negedge clock);
    reset = 1'b1;
    step();
    check("restart_pc", dut.PC_out, 64'h04);
    check("restart_ifid", {32'd0, dut.instruction_IF_ID}, {32'd0, prog[0]});
    step();
    check("restart_branch_pc", dut.PC_out, 64'h18);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end
endmodule
